// File: rtl/dds_pkg.sv
// Shared types and helpers for the DDS frequency meter.
// Optional peak tracker: DDS_FREQ_METER_PEAK_EN.
package dds_pkg;

  localparam int DDS_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    ARM_LOW,
    ARM_HIGH,
    MEAS_LOW,
    MEAS_HIGH
  } meter_state_t;

  // most-negative input maps to its positive magnitude as unsigned
  function automatic logic [31:0] abs_mag(
    input logic signed [31:0] v
  );
    return v[31] ? -v : v;
  endfunction

endpackage

// File: rtl/dds_freq_meter_if.sv
// Sample/measurement bundle between DDS source and meter.
// Master drives en/sample; slave returns the measurements.
interface dds_freq_meter_if
  import dds_pkg::*;
#(
  parameter int DATA_W = DDS_DATA_W,
  parameter int CNT_W  = 24
);

  logic                     en;
  logic signed [DATA_W-1:0] sample;
  logic [CNT_W-1:0]         period;
  logic                     period_valid;
  logic [DATA_W-1:0]        peak;
  logic                     locked;
  logic                     timeout;

  modport master (
    output en,
    output sample,
    input  period,
    input  period_valid,
    input  peak,
    input  locked,
    input  timeout
  );

  modport slave (
    input  en,
    input  sample,
    output period,
    output period_valid,
    output peak,
    output locked,
    output timeout
  );

endinterface

// File: rtl/schmitt_cross.sv
// Hysteresis zone flags for the registered sample.
// Values strictly between the thresholds raise neither flag.
module schmitt_cross #(
  parameter int DATA_W = 8,
  parameter int HYST   = 4
) (
  input  logic signed [DATA_W-1:0] i_s_q,
  output logic                     o_low,
  output logic                     o_high
);

  localparam logic signed [DATA_W-1:0] P_LO = DATA_W'(-HYST);
  localparam logic signed [DATA_W-1:0] P_HI = DATA_W'(HYST);

  assign o_low  = (i_s_q <= P_LO);
  assign o_high = (i_s_q >= P_HI);

endmodule

// File: rtl/dds_freq_meter.sv
// Period meter on rising zero crossings of a signed DDS stream.
// Define DDS_FREQ_METER_PEAK_EN to build the peak tracker.
module dds_freq_meter
  import dds_pkg::*;
#(
  parameter int DATA_W = DDS_DATA_W,
  parameter int CNT_W  = 24,
  parameter int HYST   = 4
) (
  input logic             clk,
  input logic             rst,
  dds_freq_meter_if.slave bus
);

  logic signed [DATA_W-1:0] r_s_q;
  meter_state_t             r_state;
  meter_state_t             w_next;
  logic [CNT_W-1:0]         r_cnt;
  logic [CNT_W-1:0]         r_period;
  logic                     r_pv;
  logic                     r_locked;
  logic                     r_timeout;
  logic                     w_low;
  logic                     w_high;
  logic                     w_first;
  logic                     w_cross;
  logic                     w_sat;
  logic                     w_meas;

  schmitt_cross #(
    .DATA_W(DATA_W),
    .HYST  (HYST)
  ) u_cross (
    .i_s_q (r_s_q),
    .o_low (w_low),
    .o_high(w_high)
  );

  always_comb begin
    w_next  = r_state;
    w_first = 1'b0;
    w_cross = 1'b0;
    w_sat   = 1'b0;
    w_meas  = (r_state == MEAS_LOW) ||
              (r_state == MEAS_HIGH);
    if (!bus.en) begin
      w_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE:     w_next = ARM_LOW;
        ARM_LOW:  if (w_low) w_next = ARM_HIGH;
        ARM_HIGH: if (w_high) begin
          w_next  = MEAS_LOW;
          w_first = 1'b1;
        end
        MEAS_LOW: if (w_low) w_next = MEAS_HIGH;
        MEAS_HIGH: if (w_high) begin
          w_next  = MEAS_LOW;
          w_cross = 1'b1;
        end
        default:  w_next = IDLE;
      endcase
      // a crossing on the saturating cycle still reports
      if (w_meas && !w_cross && (r_cnt == '1)) begin
        w_sat  = 1'b1;
        w_next = ARM_LOW;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s_q     <= '0;
      r_cnt     <= '0;
      r_period  <= '0;
      r_pv      <= 1'b0;
      r_locked  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_s_q     <= bus.sample;
      r_pv      <= 1'b0;
      r_timeout <= 1'b0;
      if (!bus.en) begin
        r_cnt    <= '0;
        r_locked <= 1'b0;
      end else if (w_first) begin
        r_cnt <= CNT_W'(1);
      end else if (w_cross) begin
        r_period <= r_cnt;
        r_pv     <= 1'b1;
        r_locked <= 1'b1;
        r_cnt    <= CNT_W'(1);
      end else if (w_sat) begin
        r_timeout <= 1'b1;
        r_locked  <= 1'b0;
        r_cnt     <= '0;
      end else if (w_meas) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.period       = r_period;
  assign bus.period_valid = r_pv;
  assign bus.locked       = r_locked;
  assign bus.timeout      = r_timeout;

`ifdef DDS_FREQ_METER_PEAK_EN
  logic [DATA_W-1:0] w_abs;
  logic [DATA_W-1:0] w_pk_max;
  logic [DATA_W-1:0] r_pk_run;
  logic [DATA_W-1:0] r_peak;

  assign w_abs    = DATA_W'(abs_mag(32'(r_s_q)));
  assign w_pk_max = (w_abs > r_pk_run) ? w_abs : r_pk_run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pk_run <= '0;
      r_peak   <= '0;
    end else begin
      if (w_first || w_cross) r_pk_run <= w_abs;
      else                    r_pk_run <= w_pk_max;
      if (w_cross) r_peak <= w_pk_max;
    end
  end

  assign bus.peak = r_peak;
`else
  assign bus.peak = '0;
`endif

endmodule
